toggle_arbiter: RTL and testbench

TOGGLE_ARBITER -- requirements
Module: toggle_arbiter

---
 rtl/toggle_arbiter.sv | 269 ++++++++++++++++++++++++++
 tb/tb_toggle_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_arbiter.sv
// -----------------------------------------------------------------------------
// toggle_arbiter
//
// Purpose:
//   Three raw push-buttons each request a toggle of one bit of a shared
//   3-bit register. Every button is synchronized and debounced. A debounced
//   rising edge raises a sticky pending request. A round-robin FSM
//   (IDLE -> GRANT -> COOL -> IDLE) serves one pending request at a time.
//   Leaving GRANT inverts the chosen bit of q.
//
// Ports:
//   sysclk  in   1  sole clock, rising edge
//   reset   in   1  asynchronous active-low reset
//   btn     in   3  raw asynchronous toggle requests, one per q bit
//   clr     in   1  synchronous clear: q, pending, grant and FSM to idle
//   q       out  3  shared toggle register (registered)
//   grant   out  3  one-hot grant, high only during the GRANT cycle (registered)
//   busy    out  1  FSM not in IDLE (registered)
//   led     out  4  {busy, q} (registered)
//
// Parameters:
//   DEB_CYCLES   consecutive disagreeing cycles before the debounced level
//                flips (2..255)
//   COOL_CYCLES  cycles spent in COOL after each grant (1..15)
// -----------------------------------------------------------------------------
module toggle_arbiter #(
    parameter int DEB_CYCLES  = 4,
    parameter int COOL_CYCLES = 2
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [2:0] btn,
    input  logic       clr,
    output logic [2:0] q,
    output logic [2:0] grant,
    output logic       busy,
    output logic [3:0] led
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        COOL  = 2'b10
    } state_t;

    localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
    localparam logic [3:0] COOL_LOAD = 4'(COOL_CYCLES - 1);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Next index modulo 3.
    function automatic logic [1:0] inc3(input logic [1:0] idx);
        logic [1:0] res;
        if (idx == 2'd2) begin
            res = 2'd0;
        end else begin
            res = idx + 2'd1;
        end
        return res;
    endfunction

    // One-hot decode of a bit index; out-of-range indices decode to zero.
    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] res;
        case (idx)
            2'd0:    res = 3'b001;
            2'd1:    res = 3'b010;
            2'd2:    res = 3'b100;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    // First requesting index found searching from ptr+1 (mod 3) onward.
    // Only called when at least one request is present.
    function automatic logic [1:0] rr_pick(input logic [2:0] req,
                                           input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        idx   = inc3(ptr);
        pick  = idx;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
            idx = inc3(idx);
        end
        return pick;
    endfunction

    // ------------------------------------------------------------------
    // Input conditioning state
    // ------------------------------------------------------------------
    logic [2:0] sync1_r;
    logic [2:0] sync2_r;
    logic [2:0] deb_r;
    logic [2:0] deb_d_r;
    logic [7:0] cnt_r [3];
    logic [2:0] rise_s;

    // FSM and datapath state
    state_t     state_r;
    logic [1:0] sel_r;
    logic [1:0] ptr_r;
    logic [2:0] pending_r;
    logic [3:0] cool_r;
    logic [2:0] q_r;
    logic [2:0] grant_r;
    logic       busy_r;
    logic [3:0] led_r;

    // FSM-only next values, before the clear override
    state_t     state_fsm_s;
    logic [1:0] sel_fsm_s;
    logic [1:0] ptr_fsm_s;
    logic [2:0] pending_fsm_s;
    logic [3:0] cool_fsm_s;
    logic [2:0] q_fsm_s;
    logic [2:0] grant_fsm_s;

    // Final next values
    state_t     state_nxt_s;
    logic [1:0] sel_nxt_s;
    logic [1:0] ptr_nxt_s;
    logic [2:0] pending_nxt_s;
    logic [3:0] cool_nxt_s;
    logic [2:0] q_nxt_s;
    logic [2:0] grant_nxt_s;
    logic       busy_nxt_s;

    // Two-flop synchronizer on the raw buttons.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit debounce: count disagreeing edges and flip the debounced level
    // on the edge where the count has reached DEB_CYCLES-1.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            deb_r   <= 3'b000;
            deb_d_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= 8'd0;
            end
        end else begin
            deb_d_r <= deb_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (cnt_r[i] == DEB_LAST) begin
                        deb_r[i] <= ~deb_r[i];
                        cnt_r[i] <= 8'd0;
                    end else begin
                        cnt_r[i] <= cnt_r[i] + 8'd1;
                    end
                end else begin
                    cnt_r[i] <= 8'd0;
                end
            end
        end
    end

    // A debounced 0->1 transition seen one edge later; falling edges are ignored.
    assign rise_s = deb_r & ~deb_d_r;

    // Arbitration FSM next-state and datapath logic.
    always_comb begin
        state_fsm_s   = state_r;
        sel_fsm_s     = sel_r;
        ptr_fsm_s     = ptr_r;
        pending_fsm_s = pending_r | rise_s;
        cool_fsm_s    = cool_r;
        q_fsm_s       = q_r;
        grant_fsm_s   = 3'b000;

        case (state_r)
            IDLE: begin
                if (|pending_r) begin
                    state_fsm_s = GRANT;
                    sel_fsm_s   = rr_pick(pending_r, ptr_r);
                    grant_fsm_s = onehot3(rr_pick(pending_r, ptr_r));
                end else begin
                    state_fsm_s = IDLE;
                end
            end
            GRANT: begin
                // A rise arriving on this same edge re-arms the request.
                q_fsm_s       = q_r ^ onehot3(sel_r);
                ptr_fsm_s     = sel_r;
                pending_fsm_s = (pending_r & ~onehot3(sel_r)) | rise_s;
                cool_fsm_s    = COOL_LOAD;
                state_fsm_s   = COOL;
            end
            COOL: begin
                if (cool_r == 4'd0) begin
                    state_fsm_s = IDLE;
                end else begin
                    cool_fsm_s = cool_r - 4'd1;
                end
            end
            default: begin
                state_fsm_s = IDLE;
            end
        endcase
    end

    // Clear override: wipes q, pending, grant and FSM; ptr and cool count kept.
    always_comb begin
        sel_nxt_s  = sel_fsm_s;
        cool_nxt_s = cool_fsm_s;
        if (clr) begin
            state_nxt_s   = IDLE;
            ptr_nxt_s     = ptr_r;
            pending_nxt_s = 3'b000;
            q_nxt_s       = 3'b000;
            grant_nxt_s   = 3'b000;
        end else begin
            state_nxt_s   = state_fsm_s;
            ptr_nxt_s     = ptr_fsm_s;
            pending_nxt_s = pending_fsm_s;
            q_nxt_s       = q_fsm_s;
            grant_nxt_s   = grant_fsm_s;
        end
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            sel_r     <= 2'd0;
            ptr_r     <= 2'd2;
            pending_r <= 3'b000;
            cool_r    <= 4'd0;
            q_r       <= 3'b000;
            grant_r   <= 3'b000;
            busy_r    <= 1'b0;
            led_r     <= 4'b0000;
        end else begin
            state_r   <= state_nxt_s;
            sel_r     <= sel_nxt_s;
            ptr_r     <= ptr_nxt_s;
            pending_r <= pending_nxt_s;
            cool_r    <= cool_nxt_s;
            q_r       <= q_nxt_s;
            grant_r   <= grant_nxt_s;
            busy_r    <= busy_nxt_s;
            led_r     <= {busy_nxt_s, q_nxt_s};
        end
    end

    assign q     = q_r;
    assign grant = grant_r;
    assign busy  = busy_r;
    assign led   = led_r;

endmodule

// File: tb/tb_toggle_arbiter.sv
// -----------------------------------------------------------------------------
// tb_toggle_arbiter
//
// Self-checking bench for toggle_arbiter at default parameters. Expected
// grants (value and the clock edge after which they must appear) are queued
// as stimulus is applied. A negedge monitor pops and compares them whenever
// grant is non-zero; any grant with an empty queue is an error.
// -----------------------------------------------------------------------------
module tb_toggle_arbiter;

    logic       sysclk = 1'b0;
    logic       reset;
    logic [2:0] btn;
    logic       clr;
    logic [2:0] q;
    logic [2:0] grant;
    logic       busy;
    logic [3:0] led;

    typedef struct {
        logic [2:0] g;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    toggle_arbiter #(
        .DEB_CYCLES (4),
        .COOL_CYCLES(2)
    ) dut (
        .sysclk(sysclk),
        .reset (reset),
        .btn   (btn),
        .clr   (clr),
        .q     (q),
        .grant (grant),
        .busy  (busy),
        .led   (led)
    );

    always #5 sysclk = ~sysclk;

    // Rising-edge counter: at the negedge after edge n, cyc == n.
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [2:0] g, input int at);
        exp_t e;
        e.g  = g;
        e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic wait_until(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 500) begin
            @(negedge sysclk);
            guard++;
        end
        if (cyc != n) check_eq("wait_bound", cyc, n);
    endtask

    // Scoreboard monitor: every observed grant must match the queue head.
    always @(negedge sysclk) begin
        exp_t e;
        if (reset === 1'b1 && grant !== 3'b000) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_grant", {29'd0, grant}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("grant_value", {29'd0, grant}, {29'd0, e.g});
                check_eq("grant_edge", cyc, e.at);
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        reset = 1'b0;
        btn   = 3'b000;
        clr   = 1'b0;
        step(2);
        check_eq("reset_q", {29'd0, q}, 32'd0);
        check_eq("reset_grant", {29'd0, grant}, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_led", {28'd0, led}, 32'd0);
        reset = 1'b1;
        step(2);

        // Single press of bit 0: latency and busy window.
        c0  = cyc;
        btn = 3'b001;
        push_exp(3'b001, c0 + 8);
        wait_until(c0 + 7);
        check_eq("lat_busy_pre", {31'd0, busy}, 32'd0);
        check_eq("lat_q_pre", {29'd0, q}, 32'd0);
        wait_until(c0 + 8);
        check_eq("lat_busy_grant", {31'd0, busy}, 32'd1);
        wait_until(c0 + 9);
        check_eq("lat_q_post", {29'd0, q}, 32'd1);
        check_eq("lat_busy_cool1", {31'd0, busy}, 32'd1);
        wait_until(c0 + 10);
        check_eq("lat_busy_cool2", {31'd0, busy}, 32'd1);
        wait_until(c0 + 11);
        check_eq("lat_busy_idle", {31'd0, busy}, 32'd0);
        check_eq("lat_led", {28'd0, led}, 32'd1);
        btn = 3'b000;
        step(12);

        // Short glitch on bit 1 is filtered out.
        btn = 3'b010;
        step(3);
        btn = 3'b000;
        step(15);
        check_eq("glitch_q", {29'd0, q}, 32'd1);

        // All three pressed together right after reset: round-robin order.
        reset = 1'b0;
        #1;
        check_eq("rst_async_q", {29'd0, q}, 32'd0);
        step(2);
        reset = 1'b1;
        c0  = cyc;
        btn = 3'b111;
        push_exp(3'b001, c0 + 8);
        push_exp(3'b010, c0 + 12);
        push_exp(3'b100, c0 + 16);
        wait_until(c0 + 20);
        check_eq("rr_q", {29'd0, q}, 32'd7);
        check_eq("rr_busy", {31'd0, busy}, 32'd0);
        btn = 3'b000;
        step(12);

        // Clear while cooling with bit 1 pending.
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check_eq("clr_idle_q", {29'd0, q}, 32'd0);
        c0  = cyc;
        btn = 3'b101;
        push_exp(3'b001, c0 + 8);
        push_exp(3'b100, c0 + 12);
        wait_until(c0 + 6);
        btn = 3'b111;
        wait_until(c0 + 13);
        check_eq("clr_pre_q", {29'd0, q}, 32'd5);
        check_eq("clr_pre_busy", {31'd0, busy}, 32'd1);
        clr = 1'b1;
        wait_until(c0 + 14);
        clr = 1'b0;
        check_eq("clr_q", {29'd0, q}, 32'd0);
        check_eq("clr_busy", {31'd0, busy}, 32'd0);
        check_eq("clr_led", {28'd0, led}, 32'd0);
        step(20);
        check_eq("clr_no_toggle", {29'd0, q}, 32'd0);
        btn = 3'b000;
        step(12);

        // Reset during GRANT of bit 2 aborts the toggle.
        c0  = cyc;
        btn = 3'b100;
        push_exp(3'b100, c0 + 8);
        wait_until(c0 + 8);
        #1;
        reset = 1'b0;
        #1;
        check_eq("abort_q", {29'd0, q}, 32'd0);
        check_eq("abort_led", {28'd0, led}, 32'd0);
        check_eq("abort_grant", {29'd0, grant}, 32'd0);
        btn = 3'b000;
        @(negedge sysclk);
        reset = 1'b1;
        step(20);
        check_eq("abort_after_q", {29'd0, q}, 32'd0);

        // Button held through reset is serviced after release.
        btn   = 3'b100;
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        c0    = cyc;
        push_exp(3'b100, c0 + 8);
        wait_until(c0 + 9);
        check_eq("held_q", {29'd0, q}, 32'd4);
        btn = 3'b000;
        step(12);

        // Bit 0 rises while bit 2 is being served: request held, served next.
        c0  = cyc;
        btn = 3'b100;
        push_exp(3'b100, c0 + 8);
        wait_until(c0 + 2);
        btn = 3'b101;
        push_exp(3'b001, c0 + 12);
        wait_until(c0 + 16);
        check_eq("hold_q", {29'd0, q}, 32'd1);
        btn = 3'b000;
        step(12);

        check_eq("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
